// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb master port between N_REQ requesters.
// Optional read-response timeout enabled by defining IOB_ARB_TIMEOUT_EN.
module iob_rr_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          s_avalid_i,
  input  logic [N_REQ*ADDR_W-1:0]   s_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   s_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0] s_wstrb_i,
  output logic [N_REQ-1:0]          s_ready_o,
  output logic [N_REQ-1:0]          s_rvalid_o,
  output logic [DATA_W-1:0]         s_rdata_o,
  output logic                      iob_avalid_o,
  output logic [ADDR_W-1:0]         iob_addr_o,
  output logic [DATA_W-1:0]         iob_wdata_o,
  output logic [DATA_W/8-1:0]       iob_wstrb_o,
  input  logic                      iob_rvalid_i,
  input  logic [DATA_W-1:0]         iob_rdata_i,
  input  logic                      iob_ready_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      err_o
);

  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   pick;
  logic            pick_vld;
  logic [PW-1:0]   gnext;
  logic            timeout;
  logic [ADDR_W-1:0] addr_g;
  logic [DATA_W-1:0] wdata_g;
  logic [SW-1:0]     wstrb_g;
  int              idx;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (s_avalid_i[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign gnext = (int'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + 1'b1;

  assign addr_g  = s_addr_i[int'(gidx_q)*ADDR_W +: ADDR_W];
  assign wdata_g = s_wdata_i[int'(gidx_q)*DATA_W +: DATA_W];
  assign wstrb_g = s_wstrb_i[int'(gidx_q)*SW +: SW];

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT_R, so every entry starts from zero.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == WAIT_R && !iob_rvalid_i) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
        timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    iob_avalid_o = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;
    s_ready_o    = '0;
    s_rvalid_o   = '0;
    s_rdata_o    = iob_rdata_i;
    grant_o      = '0;
    err_o        = timeout;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        grant_o[gidx_q]   = 1'b1;
        iob_avalid_o      = s_avalid_i[gidx_q];
        iob_addr_o        = addr_g;
        iob_wdata_o       = wdata_g;
        iob_wstrb_o       = wstrb_g;
        s_ready_o[gidx_q] = iob_ready_i;
        if (!s_avalid_i[gidx_q]) begin
          state_d = IDLE;
        end else if (iob_ready_i) begin
          if (|wstrb_g) begin
            state_d = IDLE;
            ptr_d   = gnext;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        grant_o[gidx_q] = 1'b1;
        if (iob_rvalid_i) begin
          s_rvalid_o[gidx_q] = 1'b1;
          state_d            = IDLE;
          ptr_d              = gnext;
        end else if (timeout) begin
          s_rvalid_o[gidx_q] = 1'b1;
          s_rdata_o          = '0;
          state_d            = IDLE;
          ptr_d              = gnext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed bench for iob_rr_arbiter with a transaction scoreboard.
// Timeout checks run when IOB_ARB_TIMEOUT_EN is defined.
module tb_iob_rr_arbiter;

  localparam int N = 2;
  localparam int A = 32;
  localparam int D = 32;
  localparam int S = D / 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   s_avalid;
  logic [N*A-1:0] s_addr;
  logic [N*D-1:0] s_wdata;
  logic [N*S-1:0] s_wstrb;
  logic [N-1:0]   s_ready;
  logic [N-1:0]   s_rvalid;
  logic [D-1:0]   s_rdata;
  logic           iob_avalid;
  logic [A-1:0]   iob_addr;
  logic [D-1:0]   iob_wdata;
  logic [S-1:0]   iob_wstrb;
  logic           iob_rvalid;
  logic [D-1:0]   iob_rdata;
  logic           iob_ready;
  logic [N-1:0]   grant;
  logic           err;

  typedef struct {
    int         g;
    logic [A-1:0] addr;
    logic [D-1:0] wdata;
    logic [S-1:0] wstrb;
  } exp_t;

  exp_t         sb[$];
  logic [D-1:0] rsb[$];
  int tests = 0;
  int fails = 0;

  iob_rr_arbiter #(
    .N_REQ(N), .ADDR_W(A), .DATA_W(D), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_avalid_i(s_avalid), .s_addr_i(s_addr),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb),
    .s_ready_o(s_ready), .s_rvalid_o(s_rvalid),
    .s_rdata_o(s_rdata),
    .iob_avalid_o(iob_avalid), .iob_addr_o(iob_addr),
    .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb),
    .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata),
    .iob_ready_i(iob_ready),
    .grant_o(grant), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setreq(input int k, input logic [A-1:0] a,
                        input logic [D-1:0] w, input logic [S-1:0] s);
    s_avalid[k]       = 1'b1;
    s_addr[k*A +: A]  = a;
    s_wdata[k*D +: D] = w;
    s_wstrb[k*S +: S] = s;
  endtask

  task automatic push(input int k, input logic [A-1:0] a,
                      input logic [D-1:0] w, input logic [S-1:0] s);
    exp_t e;
    e.g = k; e.addr = a; e.wdata = w; e.wstrb = s;
    sb.push_back(e);
  endtask

  task automatic drive(input int k, input logic [A-1:0] a,
                       input logic [D-1:0] w, input logic [S-1:0] s);
    setreq(k, a, w, s);
    push(k, a, w, s);
  endtask

  // Called in an acceptance cycle (iob_ready high).
  task automatic chk_acc(input string tag);
    exp_t e;
    logic [N-1:0] oh;
    chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      oh = '0;
      oh[e.g] = 1'b1;
      chk({tag, "_avalid"}, 64'(iob_avalid), 64'd1);
      chk({tag, "_grant"}, 64'(grant), 64'(oh));
      chk({tag, "_ready"}, 64'(s_ready), 64'(oh));
      chk({tag, "_addr"}, 64'(iob_addr), 64'(e.addr));
      chk({tag, "_wdata"}, 64'(iob_wdata), 64'(e.wdata));
      chk({tag, "_wstrb"}, 64'(iob_wstrb), 64'(e.wstrb));
    end
  endtask

  task automatic chk_rd(input string tag, input logic [N-1:0] rv);
    chk({tag, "_rvalid"}, 64'(s_rvalid), 64'(rv));
    chk({tag, "_rsb"}, 64'(rsb.size() > 0), 64'd1);
    if (rsb.size() > 0)
      chk({tag, "_rdata"}, 64'(s_rdata), 64'(rsb.pop_front()));
  endtask

  initial begin
    rst_n      = 1'b0;
    s_avalid   = '0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    iob_ready  = 1'b0;
    iob_rvalid = 1'b0;
    iob_rdata  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_avalid", 64'(iob_avalid), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single write from requester 0
    @(negedge clk);
    drive(0, 32'h100, 32'hA5A5_A5A5, 4'hF);
    iob_ready = 1'b1;
    #1;
    chk("w_idle_avalid", 64'(iob_avalid), 64'd0);
    chk("w_idle_grant", 64'(grant), 64'd0);
    @(negedge clk);
    #1 chk_acc("w");
    @(negedge clk);
    s_avalid = '0;
    #1 chk("w_done_grant", 64'(grant), 64'd0);

    // single read from requester 1, requester 0 held off
    @(negedge clk);
    drive(1, 32'h200, 32'h0, 4'h0);
    #1 chk("r_idle_grant", 64'(grant), 64'd0);
    @(negedge clk);
    #1 chk_acc("r");
    @(negedge clk);
    s_avalid = '0;
    setreq(0, 32'h300, 32'h3333_3333, 4'hF);
    #1;
    chk("r_wait_avalid", 64'(iob_avalid), 64'd0);
    chk("r_wait_ready", 64'(s_ready), 64'd0);
    chk("r_wait_rvalid", 64'(s_rvalid), 64'd0);
    chk("r_wait_grant", 64'(grant), 64'b10);
    @(negedge clk);
    iob_rvalid = 1'b1;
    iob_rdata  = 32'h1234_5678;
    rsb.push_back(32'h1234_5678);
    #1;
    chk_rd("r", 2'b10);
    chk("r_ret_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    iob_rvalid = 1'b0;
    s_avalid   = '0;
    #1 chk("r_done_grant", 64'(grant), 64'd0);

    // contention: grants alternate 0,1,0,1
    @(negedge clk);
    setreq(0, 32'h500, 32'h1111_1111, 4'hF);
    setreq(1, 32'h600, 32'h2222_2222, 4'hF);
    for (int t = 0; t < 4; t++)
      push(t % 2, (t % 2 == 0) ? 32'h500 : 32'h600,
           (t % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222, 4'hF);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1 chk_acc("rr");
      @(negedge clk);
      #1 chk("rr_gap_grant", 64'(grant), 64'd0);
    end
    s_avalid = '0;

    // backpressure: five stalled REQ cycles
    @(negedge clk);
    iob_ready = 1'b0;
    drive(0, 32'h400, 32'h4444_4444, 4'h3);
    setreq(1, 32'h700, 32'h7777_7777, 4'hF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_addr", 64'(iob_addr), 64'h400);
      chk("bp_wstrb", 64'(iob_wstrb), 64'h3);
      chk("bp_grant", 64'(grant), 64'b01);
      chk("bp_ready", 64'(s_ready), 64'd0);
    end
    @(negedge clk);
    iob_ready = 1'b1;
    #1 chk_acc("bp");
    @(negedge clk);
    s_avalid = '0;
    #1 chk("bp_done_grant", 64'(grant), 64'd0);

    // reset during WAIT_R, then a stale rvalid
    @(negedge clk);
    drive(1, 32'h800, 32'h0, 4'h0);
    @(negedge clk);
    #1 chk_acc("rst_r");
    @(negedge clk);
    s_avalid = '0;
    #1 chk("rst_wait_grant", 64'(grant), 64'b10);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_grant", 64'(grant), 64'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    iob_rvalid = 1'b1;
    iob_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rst_late_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_late_grant", 64'(grant), 64'd0);
    @(negedge clk);
    iob_rvalid = 1'b0;
    drive(0, 32'h900, 32'h9999_9999, 4'hF);
    setreq(1, 32'hA00, 32'hAAAA_AAAA, 4'hF);
    #1 chk("rst_idle_grant", 64'(grant), 64'd0);
    @(negedge clk);
    #1 chk_acc("rst_ptr");
    @(negedge clk);
    s_avalid = '0;
    #1 chk("rst_done_grant", 64'(grant), 64'd0);

    // read with no response
    @(negedge clk);
    drive(1, 32'hB00, 32'h0, 4'h0);
    @(negedge clk);
    #1 chk_acc("to_r");
    @(negedge clk);
    s_avalid  = '0;
    iob_rdata = 32'hFFFF_FFFF;
`ifdef IOB_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to_wait_err", 64'(err), 64'd0);
      chk("to_wait_rvalid", 64'(s_rvalid), 64'd0);
      chk("to_wait_grant", 64'(grant), 64'b10);
      @(negedge clk);
    end
    rsb.push_back(32'h0);
    #1;
    chk("to_err", 64'(err), 64'd1);
    chk_rd("to", 2'b10);
    @(negedge clk);
    #1;
    chk("to_err_once", 64'(err), 64'd0);
    chk("to_rvalid_once", 64'(s_rvalid), 64'd0);
    chk("to_done_grant", 64'(grant), 64'd0);
    drive(0, 32'hC00, 32'hCCCC_CCCC, 4'hF);
    @(negedge clk);
    #1 chk_acc("to_next");
    @(negedge clk);
    s_avalid = '0;
    #1 chk("to_next_grant", 64'(grant), 64'd0);
`else
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("nt_wait_err", 64'(err), 64'd0);
      chk("nt_wait_rvalid", 64'(s_rvalid), 64'd0);
      chk("nt_wait_grant", 64'(grant), 64'b10);
      @(negedge clk);
    end
    iob_rvalid = 1'b1;
    iob_rdata  = 32'hCAFE_F00D;
    rsb.push_back(32'hCAFE_F00D);
    #1 chk_rd("nt", 2'b10);
    @(negedge clk);
    iob_rvalid = 1'b0;
    #1 chk("nt_done_grant", 64'(grant), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_rr_arbiter.md
Name: iob_rr_arbiter

Overview:
- Round-robin arbiter sharing one IOb-bus master port between N_REQ IOb requesters, e.g. the VexRiscv instruction and data buses feeding a single IOb memory/peripheral port.
- Sits between the requesters and the AXI-to-IOb bridged fabric.
- One transaction in flight at a time. Grant is held from the request through write acceptance, or through read-data return.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 256, read-response timeout. Used only with IOB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_avalid_i  in  N_REQ  per-requester request valid.
- s_addr_i  in  N_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- s_wdata_i  in  N_REQ*DATA_W  packed write data.
- s_wstrb_i  in  N_REQ*DATA_W/8  packed strobes; all-zero means read.
- s_ready_o  out  N_REQ  per-requester accept.
- s_rvalid_o  out  N_REQ  per-requester read-data valid.
- s_rdata_o  out  DATA_W  read data, broadcast to all requesters.
- iob_avalid_o  out  1  master request valid.
- iob_addr_o  out  ADDR_W  master address.
- iob_wdata_o  out  DATA_W  master write data.
- iob_wstrb_o  out  DATA_W/8  master strobe.
- iob_rvalid_i  in  1  slave read-data valid.
- iob_rdata_i  in  DATA_W  slave read data.
- iob_ready_i  in  1  slave accept.
- grant_o  out  N_REQ  one-hot current grant; zero in IDLE.
- err_o  out  1  timeout pulse. Tied 0 without IOB_ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; grant=0; rr pointer=0.
  - All outputs 0.
  - An in-flight transaction is dropped. A late iob_rvalid_i arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE:
  - If any s_avalid_i is set, pick the first set bit scanning from pointer upward, wrapping at N_REQ-1→0.
  - Register the grant and go to REQ. This costs one cycle of arbitration latency.
  - No master outputs are driven active in IDLE.
- REQ:
  - iob_avalid_o = s_avalid_i[g]; addr/wdata/wstrb muxed combinationally from slice g.
  - s_ready_o[g] = iob_ready_i; other ready bits 0.
  - On iob_avalid_o & iob_ready_i:
    - wstrb≠0 (write): go to IDLE; pointer=g+1 mod N_REQ.
    - wstrb=0 (read): go to WAIT_R.
  - If s_avalid_i[g] drops before acceptance: go to IDLE, pointer unchanged.
- WAIT_R:
  - iob_avalid_o=0.
  - On iob_rvalid_i: s_rvalid_o[g]=1 in the same cycle (combinational), s_rdata_o=iob_rdata_i; go to IDLE; pointer=g+1.
  - The slave returns rvalid no earlier than the cycle after acceptance. An rvalid in the acceptance cycle is ignored.
- s_rdata_o is always iob_rdata_i. Only the granted requester's rvalid is ever asserted.
- Minimum cycles per transaction: write 2 (IDLE+REQ); read 3.
- Fairness: after a grant completes, that requester has lowest priority. With all N_REQ requesting continuously, each is served once per N_REQ transactions.
- Simultaneous events: a new s_avalid_i during REQ/WAIT_R is held off (ready=0) until the next IDLE.

Optional Feature:
- Macro: IOB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_R and increments each WAIT_R cycle without iob_rvalid_i.
  - When count reaches TIMEOUT_CYCLES: s_rvalid_o[g]=1 with s_rdata_o forced to 0 for one cycle, err_o=1 for one cycle, go to IDLE, pointer=g+1.
  - Counter resets to 0.
- Without the macro: no counter, WAIT_R waits indefinitely, err_o=0.

Test Plan:
- Single write: req0 avalid, addr=0x100, wdata=0xA5A5A5A5, wstrb=0xF; slave ready=1 → iob_avalid_o high cycle 1 with the same addr/data, s_ready_o=01 that cycle, grant_o=00 the next cycle.
- Single read: req1 addr=0x200, wstrb=0; slave accepts, rvalid+rdata=0x12345678 two cycles later → s_rvalid_o=10 with s_rdata_o=0x12345678; req0 sees no rvalid.
- Contention: both requesters continuously issue writes, ready=1 → grants alternate 0,1,0,1 over 4 transactions, each 2 cycles.
- Backpressure: ready=0 for 5 cycles during REQ → addr/wstrb stable, grant held, the other requester's ready stays 0; accepted on cycle 6.
- Reset mid-read: assert rst_n=0 in WAIT_R, release, then inject iob_rvalid_i → no s_rvalid_o, grant_o=0, pointer=0.
- With IOB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: read accepted, no rvalid → after 8 WAIT_R cycles s_rvalid_o[g]=1, s_rdata_o=0, err_o pulses once; the next request is served normally.
